// File: rtl/lsu.sv
// Load/store unit: turns one memory-stage request into a single handshaked
// bus cycle, with alignment checks, byte-lane steering and an ack timeout.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] rs2_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        align_fault,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // The counter only has to reach TIMEOUT_CYCLES-1 before the timeout fires.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              accept;
    logic              timeout_hit;
    logic              req_fault;

    logic [31:0]       addr_p0;
    logic [31:0]       wdata_p0;
    logic [3:0]        wstrb_p0;
    logic              we_p0;
    logic [2:0]        funct3_p0;
    logic [1:0]        off_p0;
    logic              fault_p0;
    logic              berr_p0;
    logic [31:0]       load_data_p1;

    // Illegal widths, stores of unsigned widths, and misaligned H/W accesses.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off,
                                        input logic store);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return off[0];
            3'b010:  return off != 2'b00;
            3'b100:  return store;
            3'b101:  return store | off[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {4{d[7:0]}};
            3'b001:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [31:0]        lane;
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        lane   = rdata >> {off, 3'b000};
        lane_b = lane[7:0];
        lane_h = lane[15:0];
        case (f3)
            3'b000:  return 32'(lane_b);
            3'b001:  return 32'(lane_h);
            3'b100:  return {24'b0, lane[7:0]};
            3'b101:  return {16'b0, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    assign req_fault = misaligned(funct3, address[1:0], !is_load);

    // Next-state logic: accept only from IDLE, ack beats timeout in ACCESS.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start && (is_load || is_store)) begin
                    accept     = 1'b1;
                    next_state = req_fault ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    next_state = DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Wait counter: cleared on acceptance, counts ACCESS cycles without ack.
    always_ff @(posedge clk) begin
        if (rst)                           wait_cnt <= '0;
        else if (accept)                   wait_cnt <= '0;
        else if (state == ACCESS && !mem_ack) wait_cnt <= wait_cnt + 1'b1;
    end

    // ---- stage p0: request capture, held stable for the whole bus cycle ----
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_p0   <= '0;
            wdata_p0  <= '0;
            wstrb_p0  <= '0;
            we_p0     <= 1'b0;
            funct3_p0 <= '0;
            off_p0    <= '0;
            fault_p0  <= 1'b0;
            berr_p0   <= 1'b0;
        end else if (accept) begin
            addr_p0   <= {address[31:2], 2'b00};
            wdata_p0  <= is_load ? 32'b0 : store_data(funct3, rs2_val);
            wstrb_p0  <= is_load ? 4'b0 : store_strb(funct3, address[1:0]);
            we_p0     <= !is_load;
            funct3_p0 <= funct3;
            off_p0    <= address[1:0];
            fault_p0  <= req_fault;
            berr_p0   <= 1'b0;
        end else if (timeout_hit) begin
            berr_p0   <= 1'b1;
        end
    end

    // ---- stage p1: load result, updated only when a load completes ----
    always_ff @(posedge clk) begin
        if (rst) begin
            load_data_p1 <= '0;
        end else if (state == ACCESS && !we_p0) begin
            if (mem_ack)          load_data_p1 <= load_extend(mem_rdata, off_p0, funct3_p0);
            else if (timeout_hit) load_data_p1 <= '0;
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign mem_req     = (state == ACCESS);
    assign mem_we      = mem_req & we_p0;
    assign mem_addr    = addr_p0;
    assign mem_wdata   = wdata_p0;
    assign mem_wstrb   = mem_req ? wstrb_p0 : 4'b0000;
    assign align_fault = done & fault_p0;
    assign bus_err     = done & berr_p0;
    assign load_data   = load_data_p1;

endmodule
